rvtu_mmmu_arb: RTL
==================

Name: rvtu_mmmu_arb

Overview:
- MMMU-side arbiter directly downstream of the RVTU-pair request channels.
- Grants one of NUM_PAIRS requesters at a time using round-robin and pulses that requester's dfp_ack.
- Captures the address word, plus the write burst for writes, into an outbound FIFO that drives the off-chip memory link.
- Routes returning read beats back to the granted requester.

Parameters:
- NUM_PAIRS, 4, number of RVTU-pair request channels.
- BURST_LEN, 4, 32-bit data beats per read or write transaction.
- TIMEOUT_CYCLES, 1024, read watchdog limit in cycles (used only when the optional feature is compiled in).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- dfp_read  in  NUM_PAIRS  per-pair read request; held until acked.
- dfp_write  in  NUM_PAIRS  per-pair write request; held until acked.
- dfp_wdata  in  NUM_PAIRS*32  per-pair address/data word; pair i occupies bits [32i+31:32i].
- dfp_ack  out  NUM_PAIRS  one-cycle grant pulse, one-hot or zero.
- dfp_rdata_valid  out  NUM_PAIRS  read beat valid for the granted pair only.
- dfp_rdata  out  32  read beat, shared by all pairs.
- mem_valid  out  1  outbound word valid.
- mem_ready  in  1  off-chip link accepts the outbound word.
- mem_data  out  32  outbound word.
- mem_hdr  out  1  outbound word is the address header.
- mem_we  out  1  transaction is a write; qualified by mem_hdr.
- mem_last  out  1  final word of the transaction.
- mem_rdata_valid  in  1  inbound read beat valid.
- mem_rdata  in  32  inbound read beat.
- arb_err  out  1  sticky read-timeout flag (optional feature only; otherwise tied 0).

Behaviour:
Reset:
- FSM goes to IDLE and the FIFO is flushed.
- All outputs are 0.
- rr_ptr is set to NUM_PAIRS-1, so pair 0 has highest priority first.
- A mid-transaction reset abandons the transaction; requesters are reset in the same domain.

FSM states: IDLE, ACK, ADDR, WDATA, RDATA, DRAIN.
- IDLE: when any request is set and the FIFO is empty, pick the first requesting pair searching from rr_ptr+1 with wrap. Latch grant g, set we = dfp_write[g], set rr_ptr = g, go to ACK. If read and write are both set on pair g, treat it as a write.
- ACK: dfp_ack[g]=1 for exactly this cycle; go to ADDR. The requester drops read/write in the following cycle.
- ADDR: sample dfp_wdata[g] and push {hdr=1, we, last=!we}. Go to WDATA if we, else DRAIN.
- WDATA: push dfp_wdata[g] each cycle with no stall, BURST_LEN beats, counted by beat_cnt (width $clog2(BURST_LEN)+1). The final beat sets last=1. Then go to DRAIN.
- DRAIN: wait for the FIFO to empty. Go to IDLE if we, else RDATA.
- RDATA: each mem_rdata_valid produces, registered one cycle later, dfp_rdata_valid[g]=1 and dfp_rdata=mem_rdata. Count BURST_LEN beats, then go to IDLE.

Timing and outbound link:
- Request seen in IDLE at cycle t: ack at t+1, address sampled at t+2, write beats at t+3..t+2+BURST_LEN.
- mem_valid = FIFO not empty; pop when mem_valid && mem_ready. The FIFO head drives mem_data/hdr/we/last.
- FIFO depth is BURST_LEN+1, so one transaction never overflows it, even with mem_ready held low.

Boundary rules:
- mem_rdata_valid outside RDATA is dropped.
- dfp_rdata holds its last value when no valid is asserted.
- A request arriving mid-transaction waits in IDLE; it never preempts.
- A single continuous requester is re-granted after each transaction completes.

Optional Feature:
- Macro: RVTU_MMMU_ARB_TIMEOUT_EN.
- With it: in RDATA, a counter resets on each beat. On reaching TIMEOUT_CYCLES, the arbiter delivers the remaining beats to g as zero data, one per cycle, sets arb_err (sticky until rst), and returns to IDLE.
- Without it: RDATA waits indefinitely and arb_err is constant 0.

Decomposition:
- Package rvtu_mmmu_arb_pkg holds:
  - the FSM state enum;
  - the FIFO entry struct {data[31:0], hdr, we, last};
  - default NUM_PAIRS and BURST_LEN constants.
- One sub-module, rvtu_mmmu_arb_fifo: synchronous FIFO, parameterised depth and entry type, with flush on rst, push/pop, empty/full.

Test Plan:
- Pair 1 write, addr 0x0000_1000, data 0xA0..0xA3, mem_ready=1 -> ack[1] at t+1; outbound hdr(we=1) 0x1000 then 0xA0..0xA3 with last on 0xA3; back to IDLE.
- Pair 2 read, addr 0x2000, mem returns 0x11..0x14 -> outbound single hdr with last=1; dfp_rdata_valid[2] for 4 cycles, each one cycle after its mem beat; valid never asserted on pairs 0, 1, 3.
- All four pairs request reads continuously -> grants 0,1,2,3,0 in order; a new ack is never issued before the previous 4 beats complete.
- Write with mem_ready held low for 20 cycles -> FIFO holds all 5 words, no loss; drains in order once ready rises; the next grant waits for empty.
- rst asserted during WDATA of pair 0 -> all outputs 0 next cycle, FIFO empty, next grant goes to pair 0 first.
- (With the timeout feature) read with no mem beats -> after 1024 cycles, 4 zero beats to g, arb_err=1 and stays set.

Source files
------------

// File: rtl/rvtu_mmmu_arb_pkg.sv
// Shared types and defaults for the RVTU-pair to MMMU arbiter.
package rvtu_mmmu_arb_pkg;

  localparam int unsigned DefNumPairs = 4;
  localparam int unsigned DefBurstLen = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StAddr,
    StWdata,
    StRdata,
    StDrain
  } arb_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        hdr;
    logic        we;
    logic        last;
  } fifo_entry_t;

endpackage

// File: rtl/rvtu_mmmu_arb_fifo.sv
// Synchronous FIFO for outbound link words; rst flushes it, head is shown without a pop.
module rvtu_mmmu_arb_fifo
  import rvtu_mmmu_arb_pkg::*;
#(
  parameter int unsigned Depth = 5,
  parameter type entry_t = fifo_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  entry_t i_wdata,
  input  logic   i_pop,
  output entry_t o_rdata,
  output logic   o_empty,
  output logic   o_full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

  entry_t          r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CntW'(Depth));
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LastIdx) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LastIdx) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rvtu_mmmu_arb.sv
// Round-robin arbiter from RVTU-pair request channels onto the off-chip memory link.
// Optional read watchdog: define RVTU_MMMU_ARB_TIMEOUT_EN.
module rvtu_mmmu_arb
  import rvtu_mmmu_arb_pkg::*;
#(
  parameter int unsigned NUM_PAIRS      = DefNumPairs,
  parameter int unsigned BURST_LEN      = DefBurstLen,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PAIRS-1:0]    dfp_read,
  input  logic [NUM_PAIRS-1:0]    dfp_write,
  input  logic [NUM_PAIRS*32-1:0] dfp_wdata,
  output logic [NUM_PAIRS-1:0]    dfp_ack,
  output logic [NUM_PAIRS-1:0]    dfp_rdata_valid,
  output logic [31:0]             dfp_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [31:0]             mem_data,
  output logic                    mem_hdr,
  output logic                    mem_we,
  output logic                    mem_last,
  input  logic                    mem_rdata_valid,
  input  logic [31:0]             mem_rdata,
  output logic                    arb_err
);

  localparam int unsigned PtrW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int unsigned CntW = $clog2(BURST_LEN) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  arb_state_e           r_state;
  logic [PtrW-1:0]      r_rr_ptr;
  logic [PtrW-1:0]      r_grant;
  logic                 r_we;
  logic [CntW-1:0]      r_beat_cnt;
  logic [NUM_PAIRS-1:0] r_ack;
  logic [NUM_PAIRS-1:0] r_rdata_valid;
  logic [31:0]          r_rdata;

  logic [NUM_PAIRS-1:0] w_req;
  logic [NUM_PAIRS-1:0] w_grant_oh;
  logic [PtrW-1:0]      w_pick;
  logic                 w_found;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  fifo_entry_t          w_push_entry;
  fifo_entry_t          w_head;

`ifdef RVTU_MMMU_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] r_to_cnt;
  logic           r_fill;
  logic           r_err;
`endif

  assign w_req      = dfp_read | dfp_write;
  assign w_grant_oh = NUM_PAIRS'(1) << r_grant;

  // First requester strictly after rr_ptr, wrapping; rr_ptr itself is checked last.
  always_comb begin
    logic [PtrW-1:0] idx;
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_PAIRS; i++) begin
      idx = PtrW'((32'(r_rr_ptr) + i) % NUM_PAIRS);
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  always_comb begin
    w_push_entry.data = dfp_wdata[32*int'(r_grant) +: 32];
    w_push_entry.hdr  = (r_state == StAddr);
    w_push_entry.we   = r_we;
    w_push_entry.last = (r_state == StAddr) ? !r_we : (r_beat_cnt == LastBeat);
  end

  assign w_push = ((r_state == StAddr) || (r_state == StWdata)) && !w_full;
  assign w_pop  = mem_valid && mem_ready;

  rvtu_mmmu_arb_fifo #(
    .Depth   (BURST_LEN + 1),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Head fields are masked so a flushed FIFO shows all-zero link outputs.
  assign mem_valid       = !w_empty;
  assign mem_data        = mem_valid ? w_head.data : '0;
  assign mem_hdr         = mem_valid && w_head.hdr;
  assign mem_we          = mem_valid && w_head.we;
  assign mem_last        = mem_valid && w_head.last;
  assign dfp_ack         = r_ack;
  assign dfp_rdata_valid = r_rdata_valid;
  assign dfp_rdata       = r_rdata;

`ifdef RVTU_MMMU_ARB_TIMEOUT_EN
  assign arb_err = r_err;
`else
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_rr_ptr      <= PtrW'(NUM_PAIRS - 1);
      r_grant       <= '0;
      r_we          <= 1'b0;
      r_beat_cnt    <= '0;
      r_ack         <= '0;
      r_rdata_valid <= '0;
      r_rdata       <= '0;
`ifdef RVTU_MMMU_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_fill        <= 1'b0;
      r_err         <= 1'b0;
`endif
    end else begin
      r_ack         <= '0;
      r_rdata_valid <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_found && w_empty) begin
            r_grant  <= w_pick;
            r_rr_ptr <= w_pick;
            r_we     <= dfp_write[w_pick];
            r_ack    <= NUM_PAIRS'(1) << w_pick;
            r_state  <= StAck;
          end
        end
        StAck: begin
          r_state <= StAddr;
        end
        StAddr: begin
          r_beat_cnt <= '0;
          r_state    <= r_we ? StWdata : StDrain;
        end
        StWdata: begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
          if (r_beat_cnt == LastBeat) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          r_beat_cnt <= '0;
`ifdef RVTU_MMMU_ARB_TIMEOUT_EN
          r_to_cnt   <= '0;
          r_fill     <= 1'b0;
`endif
          if (w_empty) begin
            r_state <= r_we ? StIdle : StRdata;
          end
        end
        StRdata: begin
`ifdef RVTU_MMMU_ARB_TIMEOUT_EN
          // After a timeout the missing beats are synthesised as zeros, one per cycle.
          if (r_fill || mem_rdata_valid) begin
            r_rdata_valid <= w_grant_oh;
            r_rdata       <= r_fill ? '0 : mem_rdata;
            r_beat_cnt    <= r_beat_cnt + 1'b1;
            r_to_cnt      <= '0;
            if (r_beat_cnt == LastBeat) begin
              r_fill  <= 1'b0;
              r_state <= StIdle;
            end
          end else if (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1)) begin
            r_fill <= 1'b1;
            r_err  <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`else
          if (mem_rdata_valid) begin
            r_rdata_valid <= w_grant_oh;
            r_rdata       <= mem_rdata;
            r_beat_cnt    <= r_beat_cnt + 1'b1;
            if (r_beat_cnt == LastBeat) begin
              r_state <= StIdle;
            end
          end
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
